// File: rtl/vga_text_pkg.sv
// Shared text-overlay definitions: colours, character codes and the 8x16 glyph
// table used by font_rom (digits, ':', '/', '?'; all other codes are blank).
package vga_text_pkg;
  localparam logic [11:0] RGB_BLACK  = 12'h000;
  localparam logic [11:0] RGB_WHITE  = 12'hFFF;
  localparam logic [11:0] RGB_GREY   = 12'h777;
  localparam logic [11:0] RGB_YELLOW = 12'hFE0;

  localparam logic [6:0] DIGIT_BASE = 7'h30;
  localparam logic [6:0] CHAR_Q     = 7'h3F;
  localparam logic [6:0] CHAR_COLON = 7'h3A;
  localparam logic [6:0] CHAR_SLASH = 7'h2F;
  localparam logic [6:0] CHAR_BLANK = 7'h00;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;

  // Row 0 is the most significant byte; bit 7 of a row is the leftmost pixel.
  function automatic logic [127:0] glyph(input logic [6:0] ch);
    case (ch)
      7'h30:   glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      7'h31:   glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      7'h32:   glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      7'h33:   glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      7'h34:   glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      7'h35:   glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      7'h36:   glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      7'h37:   glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      7'h38:   glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      7'h39:   glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      7'h3A:   glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
      7'h2F:   glyph = 128'h0000_0000_0206_0C18_3060_C080_0000_0000;
      7'h3F:   glyph = 128'h0000_7CC6_C60C_1818_1800_1818_0000_0000;
      default: glyph = '0;
    endcase
  endfunction

  function automatic logic [7:0] font_row(input logic [6:0] ch, input logic [3:0] row);
    logic [127:0] g;
    g = glyph(ch);
    font_row = g[{~row, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/font_rom.sv
// Synchronous 128-char x 16-row font ROM; address is {char[6:0], row[3:0]}.
module font_rom import vga_text_pkg::*; (
  input  logic        clk_i,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);
  always_ff @(posedge clk_i)
    data_o <= font_row(addr_i[10:4], addr_i[3:0]);
endmodule

// File: rtl/bcd_field_overlay.sv
// Renders NUM_FIELDS two-digit BCD fields with separators and edit cursors as a
// scaled text row; two-cycle pipeline built around the synchronous font ROM.
module bcd_field_overlay import vga_text_pkg::*; #(
  parameter int          NUM_FIELDS = 3,
  parameter int          SCALE_LOG2 = 2,
  parameter int          ORIGIN_X   = 64,
  parameter int          ORIGIN_Y   = 64,
  parameter logic [6:0]  SEP_CHAR   = 7'h3A,
  parameter int          BLINK_DIV  = 12_500_000,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] CUR_COLOR  = 12'hFE0,
  parameter logic [11:0] BG_COLOR   = 12'h777
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    video_on,
  input  logic                    frame_tick,
  input  logic [8*NUM_FIELDS-1:0] fields,
  input  logic [NUM_FIELDS-1:0]   bandera_cursor,
  input  logic                    blink_en,
  output logic [11:0]             graph_rgb
);
  localparam int NCELL = 3*NUM_FIELDS - 1;
  localparam int CW    = FONT_W << SCALE_LOG2;
  localparam int CH    = FONT_H << SCALE_LOG2;
  localparam int BW    = $clog2(BLINK_DIV);

  logic [8*NUM_FIELDS-1:0] fields_q;
  logic [NUM_FIELDS-1:0]   cursor_q;
  logic [BW-1:0]           blink_cnt_q;
  logic                    blink_phase_q;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      fields_q      <= '0;
      cursor_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        fields_q <= fields;
        cursor_q <= bandera_cursor;
      end
      if (blink_cnt_q == BW'(BLINK_DIV-1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else
        blink_cnt_q <= blink_cnt_q + 1'b1;
    end

  // Stage 0: region test, cell decode, ROM address.
  logic [9:0]  dx, dy;
  logic [4:0]  k;
  logic [2:0]  f;
  logic [1:0]  p;
  logic [3:0]  nib;
  logic [6:0]  ch;
  logic [3:0]  row;
  logic [2:0]  bit_s;
  logic        in_reg, sep_s, cur_s;
  logic [63:0] fld_pad;
  logic [7:0]  cur_pad;

  always_comb begin
    dx      = pix_x - 10'(ORIGIN_X);
    dy      = pix_y - 10'(ORIGIN_Y);
    in_reg  = (int'(pix_x) >= ORIGIN_X) && (int'(pix_x) < ORIGIN_X + NCELL*CW) &&
              (int'(pix_y) >= ORIGIN_Y) && (int'(pix_y) < ORIGIN_Y + CH);
    k       = 5'(dx >> (3 + SCALE_LOG2));
    // k/3 via a compare chain against multiples of three
    f       = '0;
    for (int j = 1; j < NUM_FIELDS; j++)
      if (k >= 5'(3*j)) f = 3'(j);
    p       = 2'(k - 5'(3*f));
    fld_pad = 64'(fields_q);
    cur_pad = 8'(cursor_q);
    nib     = (p == 2'd0) ? fld_pad[{f, 3'b100} +: 4] : fld_pad[{f, 3'b000} +: 4];
    sep_s   = (p == 2'd2);
    ch      = sep_s ? SEP_CHAR : (nib > 4'd9) ? CHAR_Q : {DIGIT_BASE[6:4], nib};
    row     = 4'(dy >> SCALE_LOG2);
    bit_s   = 3'(dx >> SCALE_LOG2);
    cur_s   = cur_pad[f] & ~sep_s;
  end

  logic [7:0] font_word;

  font_rom u_font (
    .clk_i  (CLK),
    .addr_i ({ch, row}),
    .data_o (font_word)
  );

  // Stage 1 flags; hide_q already folds in the blink phase seen at decode time.
  logic [2:0] bit_q;
  logic       inreg_q, sep_q, cur_q, hide_q, von_q;

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      bit_q   <= '0;
      inreg_q <= 1'b0;
      sep_q   <= 1'b0;
      cur_q   <= 1'b0;
      hide_q  <= 1'b0;
      von_q   <= 1'b0;
    end else begin
      bit_q   <= bit_s;
      inreg_q <= in_reg;
      sep_q   <= sep_s;
      cur_q   <= cur_s;
      hide_q  <= blink_en & ~blink_phase_q;
      von_q   <= video_on;
    end

  // Stage 2: colour select.
  logic [11:0] rgb_d;
  logic        fbit;

  always_comb begin
    fbit = font_word[~bit_q];
    if (!von_q)                rgb_d = 12'h000;
    else if (!inreg_q || !fbit) rgb_d = BG_COLOR;
    else if (sep_q || !cur_q)  rgb_d = FG_COLOR;
    else if (hide_q)           rgb_d = BG_COLOR;
    else                       rgb_d = CUR_COLOR;
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) graph_rgb <= 12'h000;
    else       graph_rgb <= rgb_d;
endmodule

// File: tb/tb_bcd_field_overlay.sv
// Scoreboard bench for bcd_field_overlay: a behavioural pixel model pushes the
// expected colour per driven pixel; the DUT output two cycles later is compared.
module tb_bcd_field_overlay;
  import vga_text_pkg::*;

  localparam int NF = 3, S = 1, OX = 20, OY = 10, BD = 4;
  localparam logic [6:0]  SEP = 7'h3A;
  localparam logic [11:0] FG = 12'hFFF, CUR = 12'hFE0, BG = 12'h777;
  localparam int NC = 3*NF - 1, CW = 8 << S, CH = 16 << S;

  logic          CLK = 0, RESET = 1;
  logic [9:0]    pix_x = 0, pix_y = 0;
  logic          video_on = 0, frame_tick = 0, blink_en = 0;
  logic [8*NF-1:0] fields = 0;
  logic [NF-1:0] bandera_cursor = 0;
  logic [11:0]   graph_rgb;

  bcd_field_overlay #(
    .NUM_FIELDS(NF), .SCALE_LOG2(S), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .SEP_CHAR(SEP), .BLINK_DIV(BD), .FG_COLOR(FG), .CUR_COLOR(CUR), .BG_COLOR(BG)
  ) dut (
    .CLK(CLK), .RESET(RESET), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .frame_tick(frame_tick), .fields(fields), .bandera_cursor(bandera_cursor),
    .blink_en(blink_en), .graph_rgb(graph_rgb)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  int tb_cyc = 0;
  logic [8*NF-1:0] sh_f = 0;
  logic [NF-1:0]   sh_c = 0;
  string phase = "init";

  typedef struct { logic [11:0] rgb; string tag; } exp_t;
  exp_t expq[$];

  always @(posedge CLK or posedge RESET)
    if (RESET) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input int x, input int y, input bit v);
    int dx = x - OX, dy = y - OY;
    int k, f, p;
    logic [3:0] nib;
    logic [6:0] ch;
    logic [7:0] rw;
    if (!v) return 12'h000;
    if (dx < 0 || dx >= NC*CW || dy < 0 || dy >= CH) return BG;
    k = dx / CW; f = k / 3; p = k % 3;
    nib = (p == 0) ? sh_f[8*f+4 +: 4] : sh_f[8*f +: 4];
    if (p == 2)       ch = SEP;
    else if (nib > 9) ch = 7'h3F;
    else              ch = 7'h30 + 7'(nib);
    rw = font_row(ch, 4'((dy / (1 << S)) % 16));
    if (!rw[7 - (dx / (1 << S)) % 8]) return BG;
    if (p == 2 || !sh_c[f]) return FG;
    if (!blink_en) return CUR;
    return ((tb_cyc / BD) % 2 == 1) ? CUR : BG;
  endfunction

  task automatic px(input int x, input int y, input bit v, input bit tick);
    exp_t e;
    pix_x = 10'(x); pix_y = 10'(y); video_on = v; frame_tick = tick;
    e.rgb = model(x, y, v);
    e.tag = $sformatf("%s x=%0d y=%0d", phase, x, y);
    expq.push_back(e);
    if (tick) begin sh_f = fields; sh_c = bandera_cursor; end
    @(posedge CLK); #1;
    frame_tick = 0;
    if (expq.size() == 2) begin
      e = expq.pop_front();
      chk(e.tag, graph_rgb, e.rgb);
    end
  endtask

  task automatic scan(input int y);
    for (int x = OX - 3; x < OX + NC*CW + 3; x++) px(x, y, 1'b1, 1'b0);
  endtask

  task automatic scan_rows;
    int ys[4] = '{OY + 4, OY + 9, OY + 13, OY + 21};
    foreach (ys[i]) scan(ys[i]);
  endtask

  initial begin
    fields = 24'h123456;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rgb", graph_rgb, 12'h000);
    RESET = 0;

    phase = "pre_rst";
    for (int x = OX; x < OX + 20; x++) px(x, OY + 9, 1'b1, 1'b0);
    #2 RESET = 1;
    #1;
    chk("midline_rst_rgb", graph_rgb, 12'h000);
    chk("midline_rst_cnt", 12'(dut.blink_cnt_q), 12'h000);
    expq.delete();
    sh_f = 0; sh_c = 0;
    @(posedge CLK); #1;
    RESET = 0;

    phase = "zeros"; scan_rows();

    phase = "latency";
    fields = 24'h235959;
    px(0, 0, 1'b0, 1'b1);
    scan_rows();
    scan(OY - 1);
    scan(OY + CH - 1);
    scan(OY + CH);

    phase = "tearing";
    fields = 24'h111111;
    scan_rows();
    px(OX + 5, OY + 4, 1'b1, 1'b1);
    phase = "newframe"; scan_rows();

    phase = "badbcd";
    fields = 24'h0000A3;
    px(0, 0, 1'b0, 1'b1);
    scan_rows();

    phase = "steady";
    fields = 24'h123456; bandera_cursor = 3'b010; blink_en = 0;
    px(0, 0, 1'b0, 1'b1);
    scan_rows();

    phase = "blink";
    bandera_cursor = 3'b001; blink_en = 1;
    px(0, 0, 1'b0, 1'b1);
    scan_rows();

    phase = "multi";
    bandera_cursor = 3'b101;
    px(0, 0, 1'b0, 1'b1);
    scan(OY + 9);

    phase = "vid_off";
    for (int x = OX; x < OX + 60; x++) px(x, OY + 9, (x % 3) != 0, 1'b0);

    phase = "flush";
    px(0, 0, 1'b0, 1'b0);
    px(0, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
